mul_nport_seq: RTL and testbench

Parametrised N-channel unsigned multiplier bank with a shared, selectable second operand. Each operation latches CH first operands and one second operand (din_c or din_d, chosen by sel_a & sel_b). It then computes all CH products in parallel with an iterative shift-add datapath over B_W cycles. Results are registered and held, with a start/busy/done handshake. It replaces fixed two-channel registered multiplier pairs in datapaths where area matters more than throughput.

---
 rtl/mul_nport_seq.sv | 98 +++++++++
 tb/tb_mul_nport_seq.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mul_nport_seq.sv
// N-channel unsigned shift-add multiplier bank sharing one selectable second operand.
// Every channel finishes together after B_W iteration cycles; results are held between operations.
module mul_nport_seq #(
   parameter int CH  = 2,
   parameter int A_W = 3,
   parameter int B_W = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic [CH*A_W-1:0]         din_a,
   input  logic [B_W-1:0]            din_c,
   input  logic [B_W-1:0]            din_d,
   input  logic                      sel_a,
   input  logic                      sel_b,
   output logic                      busy,
   output logic                      done,
   output logic [CH*(A_W+B_W)-1:0]   result
);

   localparam int R_W = A_W + B_W;
   localparam int CW  = (B_W > 1) ? $clog2(B_W) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(B_W - 1);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t              state, state_nxt;
   logic [CW-1:0]       cnt;
   logic [CH*A_W-1:0]   a_q;
   logic [B_W-1:0]      b_q;
   logic [CH*R_W-1:0]   acc, acc_nxt;
   logic [CH*R_W-1:0]   result_q;
   logic                last;

   function automatic logic [R_W-1:0] part_prod(input logic [A_W-1:0] a,
                                                 input logic           bit_set,
                                                 input logic [CW-1:0]  sh);
      part_prod = bit_set ? (R_W'(a) << sh) : '0;
   endfunction

   assign last = (cnt == CNT_LAST);

   always_comb begin
      acc_nxt = acc;
      for (int i = 0; i < CH; i++) begin
         acc_nxt[i*R_W +: R_W] = acc[i*R_W +: R_W]
                                 + part_prod(a_q[i*A_W +: A_W], b_q[cnt], cnt);
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = CALC;
         CALC:    if (last)  state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Operand capture, iteration and result write-back
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt      <= '0;
         a_q      <= '0;
         b_q      <= '0;
         acc      <= '0;
         result_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_q <= din_a;
                  b_q <= (sel_a & sel_b) ? din_d : din_c;
                  acc <= '0;
                  cnt <= '0;
               end
            end
            CALC: begin
               acc <= acc_nxt;
               cnt <= cnt + CW'(1);
               if (last) result_q <= acc_nxt;
            end
            default: ;
         endcase
      end
   end

   assign busy   = (state != IDLE);
   assign done   = (state == DONE);
   assign result = result_q;

endmodule

// File: tb/tb_mul_nport_seq.sv
// Directed checks of mul_nport_seq at CH=2/A_W=3/B_W=4, plus a randomized sweep
// of a CH=4/A_W=8/B_W=8 instance against a multiply reference.
module tb_mul_nport_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [5:0]  din_a;
   logic [3:0]  din_c, din_d;
   logic        sel_a, sel_b;
   logic        busy, done;
   logic [13:0] result;

   logic        start2;
   logic [31:0] din_a2;
   logic [7:0]  din_c2, din_d2;
   logic        sel_a2, sel_b2;
   logic        busy2, done2;
   logic [63:0] result2;

   int checks = 0;
   int errors = 0;

   int          done_cnt, first_done, second_done, busy_fall;
   logic        busy0;
   logic [13:0] res_pre, res_end;

   always #5 clk = ~clk;

   mul_nport_seq #(.CH(2), .A_W(3), .B_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .din_a(din_a), .din_c(din_c),
      .din_d(din_d), .sel_a(sel_a), .sel_b(sel_b), .busy(busy), .done(done),
      .result(result));

   mul_nport_seq #(.CH(4), .A_W(8), .B_W(8)) dut_wide (
      .clk(clk), .rst_n(rst_n), .start(start2), .din_a(din_a2), .din_c(din_c2),
      .din_d(din_d2), .sel_a(sel_a2), .sel_b(sel_b2), .busy(busy2), .done(done2),
      .result(result2));

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   // Issues one request (edge 0) then observes n_edges further edges.
   task automatic run_op(input logic [5:0] a, input logic [3:0] c, input logic [3:0] d,
                         input logic sa, input logic sb, input logic sb_after,
                         input logic [15:0] smask, input int n_edges);
      @(negedge clk);
      din_a = a; din_c = c; din_d = d; sel_a = sa; sel_b = sb; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; sel_b = sb_after; din_a = ~a; din_c = ~c; din_d = ~d;
      busy0 = busy;
      done_cnt = 0; first_done = -1; second_done = -1; busy_fall = -1;
      res_pre = result; res_end = result;
      for (int k = 1; k <= n_edges; k++) begin
         @(negedge clk);
         start = smask[k];
         @(posedge clk); #1;
         if (k == 3) res_pre = result;
         if (done) begin
            done_cnt++;
            if (first_done < 0) first_done = k;
            else if (second_done < 0) second_done = k;
            res_end = result;
         end
         if (!busy && busy_fall < 0) busy_fall = k;
      end
      start = 1'b0;
   endtask

   initial begin
      logic [13:0] prev;
      logic [7:0]  bsel;
      logic [63:0] exp2;
      int          dedge;

      rst_n = 1'b0; start = 1'b0; din_a = '0; din_c = '0; din_d = '0;
      sel_a = 1'b0; sel_b = 1'b0;
      start2 = 1'b0; din_a2 = '0; din_c2 = '0; din_d2 = '0; sel_a2 = 1'b0; sel_b2 = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_result", result, 0);
      @(negedge clk); rst_n = 1'b1;

      // Basic: b=din_c=9 -> ch0 7*9=63, ch1 5*9=45
      run_op({3'd5, 3'd7}, 4'd9, 4'd15, 1'b1, 1'b0, 1'b1, 16'h0, 8);
      chk("basic_busy_edge0", busy0, 1);
      chk("basic_result", res_end, {7'd45, 7'd63});
      chk("basic_done_edge", first_done, 4);
      chk("basic_done_count", done_cnt, 1);
      chk("basic_busy_fall", busy_fall, 5);
      chk("basic_hold_after", result, {7'd45, 7'd63});

      // Select path d=15 -> 105, 75; sel_b dropped after the start edge
      run_op({3'd5, 3'd7}, 4'd9, 4'd15, 1'b1, 1'b1, 1'b0, 16'h0, 8);
      chk("sel_held_until_done", res_pre, {7'd45, 7'd63});
      chk("sel_result", res_end, {7'd75, 7'd105});
      chk("sel_done_edge", first_done, 4);

      // Zero operands: full latency, result 0
      run_op(6'd0, 4'd9, 4'd15, 1'b0, 1'b0, 1'b0, 16'h0, 8);
      chk("a0_held", res_pre, {7'd75, 7'd105});
      chk("a0_result", res_end, 0);
      chk("a0_done_edge", first_done, 4);
      run_op({3'd5, 3'd7}, 4'd0, 4'd15, 1'b0, 1'b1, 1'b1, 16'h0, 8);
      chk("b0_result", res_end, 0);
      chk("b0_done_edge", first_done, 4);

      // Max operands: 7*15 = 105 on both channels
      run_op({3'd7, 3'd7}, 4'd3, 4'd15, 1'b1, 1'b1, 1'b1, 16'h0, 8);
      chk("max_result", res_end, {7'd105, 7'd105});

      // Mixed: ch0 3*11=33, ch1 6*11=66
      run_op({3'd6, 3'd3}, 4'd11, 4'd2, 1'b0, 1'b1, 1'b0, 16'h0, 8);
      chk("mix_result", res_end, {7'd66, 7'd33});

      // start pulses at edges 1, 2, 5 are ignored
      run_op({3'd2, 3'd1}, 4'd5, 4'd0, 1'b0, 1'b0, 1'b0, 16'b0000_0000_0010_0110, 10);
      chk("ign_done_count", done_cnt, 1);
      chk("ign_busy_fall", busy_fall, 5);
      chk("ign_idle_after", busy, 0);
      chk("ign_result", res_end, {7'd10, 7'd5});

      // start held high: operations every 6 cycles
      run_op({3'd1, 3'd1}, 4'd1, 4'd1, 1'b0, 1'b0, 1'b0, 16'hFFFF, 11);
      chk("cont_first_done", first_done, 4);
      chk("cont_second_done", second_done, 10);
      repeat (8) @(posedge clk);
      #1;
      chk("cont_drained", busy, 0);

      // Asynchronous reset between edges 2 and 3
      run_op({3'd5, 3'd7}, 4'd9, 4'd15, 1'b1, 1'b0, 1'b0, 16'h0, 2);
      prev = result;
      chk("rst_pre_busy", busy, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_result", result, 0);
      chk("rst_prev_nonzero", (prev != 14'd0), 1);
      @(negedge clk); rst_n = 1'b1;
      done_cnt = 0;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk); #1;
         if (done || busy) done_cnt++;
      end
      chk("rst_quiet", done_cnt, 0);
      run_op({3'd4, 3'd3}, 4'd7, 4'd1, 1'b0, 1'b0, 1'b0, 16'h0, 8);
      chk("rst_recover_result", res_end, {7'd28, 7'd21});
      chk("rst_recover_done", first_done, 4);

      // Wide instance sweep against a multiply reference
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         din_a2 = $urandom; din_c2 = 8'($urandom); din_d2 = 8'($urandom);
         sel_a2 = 1'($urandom); sel_b2 = 1'($urandom); start2 = 1'b1;
         if (n == 0) begin din_a2 = 32'hFFFF_FFFF; din_c2 = 8'hFF; sel_a2 = 1'b0; end
         bsel = (sel_a2 & sel_b2) ? din_d2 : din_c2;
         exp2 = '0;
         for (int i = 0; i < 4; i++)
            exp2[i*16 +: 16] = 16'(din_a2[i*8 +: 8]) * 16'(bsel);
         @(posedge clk); #1;
         start2 = 1'b0; din_a2 = ~din_a2; din_c2 = ~din_c2; din_d2 = ~din_d2;
         sel_a2 = ~sel_a2; sel_b2 = ~sel_b2;
         dedge = -1;
         for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (done2 && dedge < 0) begin
               dedge = k;
               chk("sweep_result", result2, exp2);
            end
         end
         chk("sweep_done_edge", dedge, 8);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
